// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
//
// Next-PC generator and program-counter register for the single-cycle RISC-V
// core. Sits between the branch/jump/trap target logic and instruction memory.
//
// Each cycle one next-PC source is chosen. The order, from highest to lowest,
// is: trap, then the highest-index src_req, then the sequential pc + INC.
// A redirect that arrives while the core is stalled is held in a one-entry
// pending buffer, so it is not lost. A misaligned source target is rejected
// and reported.
//
// Ports:
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   stall          hold PC this cycle (a trap still takes effect)
//   src_req        per-source redirect request; the highest index wins
//   src_tgt        packed targets; source i is at [i*XLEN +: XLEN]
//   trap_valid     trap redirect; overrides everything, including stall
//   trap_vec       trap handler address (low ALIGN_BITS are forced to zero)
//   pc             current PC (registered)
//   pc_plus_inc    pc + INC (combinational)
//   pc_valid       pc is a valid fetch address
//   redirected     1-cycle pulse: pc was loaded from a non-sequential target
//   misalign_err   1-cycle pulse: the selected source target was rejected
//   misalign_addr  offending target, captured when misalign_err is raised
//   redirect_cnt   saturating count of redirect pulses
//                  (present only when PC_REDIRECT_CNT_EN is defined)
//
// Optional feature macro: PC_REDIRECT_CNT_EN
// -----------------------------------------------------------------------------
module pc_next_unit #(
    parameter int unsigned         XLEN         = 32,
    parameter int unsigned         NUM_SRC      = 4,
    parameter logic [XLEN-1:0]     RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned         ALIGN_BITS   = 2,
    parameter int unsigned         INC          = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic [NUM_SRC-1:0]      src_req,
    input  logic [NUM_SRC*XLEN-1:0] src_tgt,
    input  logic                    trap_valid,
    input  logic [XLEN-1:0]         trap_vec,
    output logic [XLEN-1:0]         pc,
    output logic [XLEN-1:0]         pc_plus_inc,
    output logic                    pc_valid,
    output logic                    redirected,
    output logic                    misalign_err,
    output logic [XLEN-1:0]         misalign_addr
`ifdef PC_REDIRECT_CNT_EN
    ,
    output logic [31:0]             redirect_cnt
`endif
);

    // Bits that must be zero in any accepted target.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t            state_r;
    logic [XLEN-1:0]   pc_r;
    logic              pc_valid_r;
    logic              redirected_r;
    logic              misalign_err_r;
    logic [XLEN-1:0]   misalign_addr_r;
    logic [XLEN-1:0]   pend_tgt_r;

    logic              src_hit_s;
    logic [XLEN-1:0]   src_sel_tgt_s;
    logic              src_misalign_s;
    logic [XLEN-1:0]   trap_tgt_s;
    logic [XLEN-1:0]   pc_plus_inc_s;

    // Priority select among the redirect sources. The loop runs in ascending
    // order, so the highest requesting index is the one left in place.
    always_comb begin
        src_hit_s     = 1'b0;
        src_sel_tgt_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_req[i]) begin
                src_hit_s     = 1'b1;
                src_sel_tgt_s = src_tgt[i*XLEN +: XLEN];
            end else begin
                // A source that is not requesting leaves the current winner.
            end
        end
    end

    assign src_misalign_s = src_hit_s && ((src_sel_tgt_s & ALIGN_MASK) != '0);
    assign trap_tgt_s     = trap_vec & ~ALIGN_MASK;
    assign pc_plus_inc_s  = pc_r + XLEN'(INC);

    // PC state machine: boot, then the run/pending redirect handling, with a
    // registered PC and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_BOOT;
            pc_r            <= RESET_VECTOR;
            pc_valid_r      <= 1'b0;
            redirected_r    <= 1'b0;
            misalign_err_r  <= 1'b0;
            misalign_addr_r <= '0;
            pend_tgt_r      <= '0;
        end else begin
            redirected_r   <= 1'b0;
            misalign_err_r <= 1'b0;
            case (state_r)
                ST_BOOT: begin
                    // The first edge out of reset only validates the PC.
                    state_r    <= ST_RUN;
                    pc_valid_r <= 1'b1;
                end
                ST_RUN, ST_PEND: begin
                    if (trap_valid) begin
                        pc_r         <= trap_tgt_s;
                        redirected_r <= 1'b1;
                        pend_tgt_r   <= '0;
                        state_r      <= ST_RUN;
                    end else if (src_misalign_s) begin
                        // The target is rejected. The PC, the pending buffer
                        // and the state stay as they are.
                        misalign_err_r  <= 1'b1;
                        misalign_addr_r <= src_sel_tgt_s;
                    end else if (stall) begin
                        if (src_hit_s) begin
                            // The latest request during a stall wins.
                            pend_tgt_r <= src_sel_tgt_s;
                            state_r    <= ST_PEND;
                        end else begin
                            pend_tgt_r <= pend_tgt_r;
                        end
                    end else if (src_hit_s) begin
                        // A fresh request takes priority over a buffered one.
                        pc_r         <= src_sel_tgt_s;
                        redirected_r <= 1'b1;
                        pend_tgt_r   <= '0;
                        state_r      <= ST_RUN;
                    end else if (state_r == ST_PEND) begin
                        pc_r         <= pend_tgt_r;
                        redirected_r <= 1'b1;
                        pend_tgt_r   <= '0;
                        state_r      <= ST_RUN;
                    end else begin
                        pc_r <= pc_plus_inc_s;
                    end
                end
                default: begin
                    // An unreachable encoding restarts the boot sequence.
                    state_r    <= ST_BOOT;
                    pc_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc            = pc_r;
    assign pc_plus_inc   = pc_plus_inc_s;
    assign pc_valid      = pc_valid_r;
    assign redirected    = redirected_r;
    assign misalign_err  = misalign_err_r;
    assign misalign_addr = misalign_addr_r;

`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt_r;

    // Saturating count of the cycles in which redirected is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_r <= 32'h0000_0000;
        end else if (redirected_r && (redirect_cnt_r != 32'hFFFF_FFFF)) begin
            redirect_cnt_r <= redirect_cnt_r + 32'd1;
        end else begin
            redirect_cnt_r <= redirect_cnt_r;
        end
    end

    assign redirect_cnt = redirect_cnt_r;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

    localparam int NS = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 stall;
    logic [NS-1:0]        src_req;
    logic [31:0]          tgt [NS];
    logic [NS*32-1:0]     src_tgt;
    logic                 trap_valid;
    logic [31:0]          trap_vec;

    // Index 0: ALIGN_BITS=2, index 1: ALIGN_BITS=1; both see the same stimulus.
    logic [1:0][31:0]     pc_o, ppi_o, maddr_o;
    logic [1:0]           valid_o, redir_o, merr_o;
`ifdef PC_REDIRECT_CNT_EN
    logic [1:0][31:0]     cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    assign src_tgt = {tgt[3], tgt[2], tgt[1], tgt[0]};

    pc_next_unit #(.XLEN(32), .NUM_SRC(NS), .RESET_VECTOR(32'h0), .ALIGN_BITS(2), .INC(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .src_req(src_req), .src_tgt(src_tgt),
        .trap_valid(trap_valid), .trap_vec(trap_vec), .pc(pc_o[0]), .pc_plus_inc(ppi_o[0]),
        .pc_valid(valid_o[0]), .redirected(redir_o[0]), .misalign_err(merr_o[0]),
        .misalign_addr(maddr_o[0])
`ifdef PC_REDIRECT_CNT_EN
        , .redirect_cnt(cnt_o[0])
`endif
    );

    pc_next_unit #(.XLEN(32), .NUM_SRC(NS), .RESET_VECTOR(32'h0), .ALIGN_BITS(1), .INC(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .src_req(src_req), .src_tgt(src_tgt),
        .trap_valid(trap_valid), .trap_vec(trap_vec), .pc(pc_o[1]), .pc_plus_inc(ppi_o[1]),
        .pc_valid(valid_o[1]), .redirected(redir_o[1]), .misalign_err(merr_o[1]),
        .misalign_addr(maddr_o[1])
`ifdef PC_REDIRECT_CNT_EN
        , .redirect_cnt(cnt_o[1])
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic        m_boot   [2];
    logic        m_valid  [2];
    logic [31:0] m_pc     [2];
    logic        m_redir  [2];
    logic        m_merr   [2];
    logic [31:0] m_maddr  [2];
    logic        m_have_pend [2];
    logic [31:0] m_pend   [2];
    logic [31:0] m_cnt    [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_boot[k] = 1'b0; m_valid[k] = 1'b0; m_pc[k] = 32'h0;
            m_redir[k] = 1'b0; m_merr[k] = 1'b0; m_maddr[k] = 32'h0;
            m_have_pend[k] = 1'b0; m_pend[k] = 32'h0; m_cnt[k] = 32'h0;
        end
    endtask

    // Advance one instance's model by one clock edge using the current inputs.
    task automatic model_edge(input int k);
        logic [31:0] low;
        int          winner;
        low = (k == 0) ? 32'h3 : 32'h1;
        winner = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            if (winner < 0 && src_req[i]) winner = i;
        end
        if (m_redir[k] && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 32'd1;
        m_redir[k] = 1'b0;
        m_merr[k]  = 1'b0;
        if (!m_boot[k]) begin
            m_boot[k]  = 1'b1;
            m_valid[k] = 1'b1;
        end else if (trap_valid) begin
            m_pc[k] = trap_vec & ~low;
            m_redir[k] = 1'b1;
            m_have_pend[k] = 1'b0;
        end else if (winner >= 0 && (tgt[winner] % (low + 32'd1)) != 32'd0) begin
            m_merr[k]  = 1'b1;
            m_maddr[k] = tgt[winner];
        end else if (stall) begin
            if (winner >= 0) begin
                m_have_pend[k] = 1'b1;
                m_pend[k] = tgt[winner];
            end
        end else if (winner >= 0 || m_have_pend[k]) begin
            m_pc[k] = (winner >= 0) ? tgt[winner] : m_pend[k];
            m_redir[k] = 1'b1;
            m_have_pend[k] = 1'b0;
        end else begin
            m_pc[k] = m_pc[k] + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pc[%0d]", k),            pc_o[k],    m_pc[k]);
            chk($sformatf("pc_plus_inc[%0d]", k),   ppi_o[k],   m_pc[k] + 32'd4);
            chk($sformatf("pc_valid[%0d]", k),      {31'd0, valid_o[k]}, {31'd0, m_valid[k]});
            chk($sformatf("redirected[%0d]", k),    {31'd0, redir_o[k]}, {31'd0, m_redir[k]});
            chk($sformatf("misalign_err[%0d]", k),  {31'd0, merr_o[k]},  {31'd0, m_merr[k]});
            chk($sformatf("misalign_addr[%0d]", k), maddr_o[k], m_maddr[k]);
`ifdef PC_REDIRECT_CNT_EN
            chk($sformatf("redirect_cnt[%0d]", k),  cnt_o[k],   m_cnt[k]);
`endif
        end
    endtask

    // One clock edge: step the model, then sample #1 after the edge.
    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic st, input logic [3:0] rq, input logic [31:0] a, b, c, d,
                         input logic tr, input logic [31:0] tv);
        stall = st; src_req = rq;
        tgt[0] = a; tgt[1] = b; tgt[2] = c; tgt[3] = d;
        trap_valid = tr; trap_vec = tv;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st;
        logic [3:0]  rq;
        logic [31:0] t0, t1, t2, t3;
        logic        tr;
        logic [31:0] tv;
        logic [31:0] exp_pc;
        logic        exp_redir;
        logic        exp_merr;
        logic [31:0] exp_maddr;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [3:0] rq,
                                input logic [31:0] t0, t1, t2, t3,
                                input logic tr, input logic [31:0] tv,
                                input logic [31:0] epc, input logic er, input logic em,
                                input logic [31:0] ea);
        vec_t v;
        v.st = st; v.rq = rq; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
        v.tr = tr; v.tv = tv; v.exp_pc = epc; v.exp_redir = er; v.exp_merr = em;
        v.exp_maddr = ea;
        return v;
    endfunction

    vec_t vecs [25];

    initial begin
        logic [31:0] r;
        clk = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        model_reset();

        //            st    req      t0            t1            t2        t3        tr    tvec           pc            rd    me    maddr
        vecs[0]  = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h0,        1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h4,        1'b0, 1'b0, 32'h0);
        vecs[2]  = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h8,        1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 4'b0101, 32'h100,      32'h0,        32'h200,  32'h0,    1'b0, 32'h0,         32'h200,      1'b1, 1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h204,      1'b0, 1'b0, 32'h0);
        vecs[5]  = mk(1'b1, 4'b0010, 32'h0,        32'h340,      32'h0,    32'h0,    1'b0, 32'h0,         32'h204,      1'b0, 1'b0, 32'h0);
        vecs[6]  = mk(1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h204,      1'b0, 1'b0, 32'h0);
        vecs[7]  = mk(1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h204,      1'b0, 1'b0, 32'h0);
        vecs[8]  = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h340,      1'b1, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h344,      1'b0, 1'b0, 32'h0);
        vecs[10] = mk(1'b0, 4'b0010, 32'h0,        32'h102,      32'h0,    32'h0,    1'b0, 32'h0,         32'h344,      1'b0, 1'b1, 32'h102);
        vecs[11] = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h348,      1'b0, 1'b0, 32'h102);
        vecs[12] = mk(1'b1, 4'b1000, 32'h0,        32'h0,        32'h0,    32'h500,  1'b0, 32'h0,         32'h348,      1'b0, 1'b0, 32'h102);
        vecs[13] = mk(1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b1, 32'h8000_0007, 32'h8000_0004, 1'b1, 1'b0, 32'h102);
        vecs[14] = mk(1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h8000_0004, 1'b0, 1'b0, 32'h102);
        vecs[15] = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h8000_0008, 1'b0, 1'b0, 32'h102);
        vecs[16] = mk(1'b0, 4'b0001, 32'hFFFF_FFFC, 32'h0,       32'h0,    32'h0,    1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 1'b0, 32'h102);
        vecs[17] = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h0,        1'b0, 1'b0, 32'h102);
        vecs[18] = mk(1'b0, 4'b0010, 32'h0,        32'h103,      32'h0,    32'h0,    1'b1, 32'h40,        32'h40,       1'b1, 1'b0, 32'h102);
        vecs[19] = mk(1'b1, 4'b0001, 32'h600,      32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h40,       1'b0, 1'b0, 32'h102);
        vecs[20] = mk(1'b0, 4'b0100, 32'h0,        32'h0,        32'h700,  32'h0,    1'b0, 32'h0,         32'h700,      1'b1, 1'b0, 32'h102);
        vecs[21] = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h704,      1'b0, 1'b0, 32'h102);
        vecs[22] = mk(1'b1, 4'b0001, 32'h800,      32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h704,      1'b0, 1'b0, 32'h102);
        vecs[23] = mk(1'b1, 4'b0010, 32'h0,        32'h900,      32'h0,    32'h0,    1'b0, 32'h0,         32'h704,      1'b0, 1'b0, 32'h102);
        vecs[24] = mk(1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0,    1'b0, 32'h0,         32'h900,      1'b1, 1'b0, 32'h102);

        // Reset state, checked while rst_n is low, then released between edges.
        #12;
        check_all();
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].st, vecs[i].rq, vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3,
                  vecs[i].tr, vecs[i].tv);
            step();
            chk($sformatf("vec%0d.pc", i),     pc_o[0], vecs[i].exp_pc);
            chk($sformatf("vec%0d.redir", i),  {31'd0, redir_o[0]}, {31'd0, vecs[i].exp_redir});
            chk($sformatf("vec%0d.merr", i),   {31'd0, merr_o[0]},  {31'd0, vecs[i].exp_merr});
            chk($sformatf("vec%0d.maddr", i),  maddr_o[0], vecs[i].exp_maddr);
            chk($sformatf("vec%0d.valid", i),  {31'd0, valid_o[0]}, 32'd1);
            if (i == 10) begin
                // With ALIGN_BITS=1 the 0x102 target is legal and loads.
                chk("align1_load.pc",   pc_o[1], 32'h102);
                chk("align1_load.merr", {31'd0, merr_o[1]}, 32'd0);
            end
        end

        // Mid-run reset with a pending redirect: it must be discarded.
        drive(1'b1, 4'b0001, 32'hA00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        do_reset();
        chk("midreset.pc",    pc_o[0], 32'h0);
        chk("midreset.valid", {31'd0, valid_o[0]}, 32'd0);
        step();
        chk("postreset.boot_pc", pc_o[0], 32'h0);
        step();
        chk("postreset.no_stale", pc_o[0], 32'h4);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            stall   = ($urandom_range(0, 9) < 4);
            src_req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            for (int i = 0; i < NS; i++) begin
                r = $urandom;
                case ($urandom_range(0, 9))
                    0:       tgt[i] = r | 32'h1;
                    1:       tgt[i] = 32'hFFFF_FFF0 | (r & 32'hC);
                    2:       tgt[i] = (r & 32'hFFFF_FFFC) | 32'h2;
                    default: tgt[i] = r & 32'hFFFF_FFFC;
                endcase
            end
            trap_valid = ($urandom_range(0, 19) == 0);
            trap_vec   = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
